// File: rtl/text_overlay_gen_pkg.sv
// Shared widths and FSM encodings for the text overlay stage.
// Glyph geometry matches the 512x8 character ROM it drives.
package text_overlay_gen_pkg;

  localparam int TEXT_CODE_W = 6;
  localparam int GLYPH_ROWS  = 8;
  localparam int GLYPH_W     = 8;
  localparam int ROM_ADDR_W  = 9;
  localparam int GY_W        = $clog2(GLYPH_ROWS);
  localparam int GX_W        = $clog2(GLYPH_W);
  localparam int HV_W        = 10;
  localparam int CELL_AW     = 11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/text_overlay_gen_if.sv
// Raster, buffer-write, cursor and glyph-ROM bus of the overlay.
// master = raster source / ROM side, slave = overlay stage.
interface text_overlay_gen_if;
  import text_overlay_gen_pkg::*;

  logic                   pix_en;
  logic [HV_W-1:0]        hcount;
  logic [HV_W-1:0]        vcount;
  logic                   video_on;
  logic                   hsync_in;
  logic                   vsync_in;
  logic                   wr_en;
  logic [CELL_AW-1:0]     wr_addr;
  logic [TEXT_CODE_W-1:0] wr_char;
  logic                   clear_req;
  logic                   cur_en;
  logic [5:0]             cur_col;
  logic [4:0]             cur_row;
  logic [ROM_ADDR_W-1:0]  rom_addr;
  logic [GLYPH_W-1:0]     rom_data;
  logic                   pixel_on;
  logic                   video_on_o;
  logic                   hsync_o;
  logic                   vsync_o;
  logic                   busy;

  modport master (
    output pix_en, hcount, vcount, video_on,
    output hsync_in, vsync_in,
    output wr_en, wr_addr, wr_char, clear_req,
    output cur_en, cur_col, cur_row, rom_data,
    input  rom_addr, pixel_on, video_on_o,
    input  hsync_o, vsync_o, busy
  );

  modport slave (
    input  pix_en, hcount, vcount, video_on,
    input  hsync_in, vsync_in,
    input  wr_en, wr_addr, wr_char, clear_req,
    input  cur_en, cur_col, cur_row, rom_data,
    output rom_addr, pixel_on, video_on_o,
    output hsync_o, vsync_o, busy
  );

endinterface

// File: rtl/text_overlay_gen_buf_ram.sv
// Text buffer: one write port, one registered read port.
// A same-address read and write returns the old word.
module text_buf_ram #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/text_overlay_gen.sv
// Text-mode overlay: char buffer, glyph ROM addressing,
// pixel select, sync alignment and a blinking cursor.
module text_overlay_gen
  import text_overlay_gen_pkg::*;
#(
  parameter int COLS         = 40,
  parameter int ROWS         = 30,
  parameter int SCALE_SHIFT  = 1,
  parameter int BLINK_FRAMES = 30
) (
  input logic               clk,
  input logic               reset_n,
  text_overlay_gen_if.slave bus
);

  localparam int CELLS = COLS * ROWS;
  localparam int SH    = GY_W + SCALE_SHIFT;
  localparam int BW    = $clog2(BLINK_FRAMES + 1);

  localparam logic [HV_W-1:0]    COLS_V = HV_W'(COLS);
  localparam logic [HV_W-1:0]    ROWS_V = HV_W'(ROWS);
  localparam logic [CELL_AW-1:0] COLS_A = CELL_AW'(COLS);
  localparam logic [CELL_AW-1:0] CELLS_A = CELL_AW'(CELLS);
  localparam logic [CELL_AW-1:0] CLR_LAST = CELL_AW'(CELLS - 1);
  localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [GX_W-1:0]    GX_MAX = GX_W'(GLYPH_W - 1);

  state_e             state_q;
  logic [CELL_AW-1:0] clr_idx_q;
  logic               busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else if (bus.clear_req) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          if (clr_idx_q == CLR_LAST) begin
            state_q   <= ST_RUN;
            clr_idx_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        ST_RUN: ;
      endcase
    end
  end

  logic          frame_tick;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_ph_q;

  assign frame_tick = bus.pix_en & (bus.hcount == '0)
                    & (bus.vcount == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  logic [HV_W-1:0]    col_s0, row_s0;
  logic               in_s0;
  logic [CELL_AW-1:0] rd_addr_s0;
  logic [GY_W-1:0]    gy_s0;
  logic [GX_W-1:0]    gx_s0;

  assign col_s0 = bus.hcount >> SH;
  assign row_s0 = bus.vcount >> SH;
  assign gy_s0  = bus.vcount[SCALE_SHIFT +: GY_W];
  assign gx_s0  = bus.hcount[SCALE_SHIFT +: GX_W];
  assign in_s0  = bus.video_on & (col_s0 < COLS_V)
                & (row_s0 < ROWS_V);
  // Off-screen coords would index past the buffer, so park them at 0.
  assign rd_addr_s0 = in_s0
    ? CELL_AW'(row_s0) * COLS_A + CELL_AW'(col_s0) : '0;

  logic                   we;
  logic [CELL_AW-1:0]     wa;
  logic [TEXT_CODE_W-1:0] wd;
  logic [TEXT_CODE_W-1:0] code_s1;
  logic                   clearing;

  assign clearing = (state_q == ST_CLEAR);
  assign we = clearing
            | (bus.wr_en & (bus.wr_addr < CELLS_A));
  assign wa = clearing ? clr_idx_q : bus.wr_addr;
  assign wd = clearing ? '0 : bus.wr_char;

  text_buf_ram #(
    .DEPTH (CELLS),
    .AW    (CELL_AW),
    .DW    (TEXT_CODE_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wa),
    .wdata_i (wd),
    .re_i    (bus.pix_en),
    .raddr_i (rd_addr_s0),
    .rdata_o (code_s1)
  );

  logic [GY_W-1:0]       gy1_q;
  logic [GX_W-1:0]       gx1_q, gx2_q;
  logic                  in1_q, in2_q;
  logic [HV_W-1:0]       col1_q, row1_q;
  logic [2:0]            vid1_q, vid2_q, vid3_q;
  logic                  hit_s1, hit2_q;
  logic [ROM_ADDR_W-1:0] rom_addr_q;
  logic                  pix_d, pix_q;

  assign hit_s1 = bus.cur_en
                & (col1_q == HV_W'(bus.cur_col))
                & (row1_q == HV_W'(bus.cur_row));
  assign pix_d = in2_q
    & (bus.rom_data[GX_MAX - gx2_q] ^ (hit2_q & blink_ph_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gy1_q      <= '0;
      gx1_q      <= '0;
      in1_q      <= 1'b0;
      col1_q     <= '0;
      row1_q     <= '0;
      vid1_q     <= '0;
      rom_addr_q <= '0;
      gx2_q      <= '0;
      in2_q      <= 1'b0;
      hit2_q     <= 1'b0;
      vid2_q     <= '0;
      vid3_q     <= '0;
      pix_q      <= 1'b0;
    end else begin
      if (bus.pix_en) begin
        gy1_q      <= gy_s0;
        gx1_q      <= gx_s0;
        in1_q      <= in_s0;
        col1_q     <= col_s0;
        row1_q     <= row_s0;
        vid1_q     <= {bus.video_on, bus.hsync_in, bus.vsync_in};
        rom_addr_q <= {code_s1, gy1_q};
        gx2_q      <= gx1_q;
        in2_q      <= in1_q;
        hit2_q     <= hit_s1;
        vid2_q     <= vid1_q;
        vid3_q     <= vid2_q;
      end
      if (clearing) pix_q <= 1'b0;
      else if (bus.pix_en) pix_q <= pix_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.pixel_on   = pix_q;
  assign bus.video_on_o = vid3_q[2];
  assign bus.hsync_o    = vid3_q[1];
  assign bus.vsync_o    = vid3_q[0];
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_text_overlay_gen.sv
// Directed bench for text_overlay_gen with a tiny glyph ROM.
// Pixel for an input sampled at edge k appears after edge k+2.
module tb_text_overlay_gen;
  import text_overlay_gen_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  text_overlay_gen_if bus();

  text_overlay_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [8:0] a);
    logic [5:0] c;
    c = a[8:3];
    case (a)
      9'h008:  glyph = 8'h18;
      9'h188:  glyph = 8'hFF;
      9'h189:  glyph = 8'h18;
      default: glyph = (c == 6'd0) ? 8'h00 : 8'h81;
    endcase
  endfunction

  assign bus.rom_data = glyph(bus.rom_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.hcount   = 10'd700;
    bus.vcount   = 10'd500;
    bus.video_on = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wr(input int a, input int c);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 11'(a);
    bus.wr_char = 6'(c);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic scan(input int v0, input int nv,
                      input int h0, input int nh,
                      input logic vo,
                      output logic [255:0] pix,
                      output logic [8:0] ra0);
    int n;
    n   = nv * nh;
    pix = '0;
    ra0 = '0;
    for (int k = 0; k < n + 2; k++) begin
      if (k < n) begin
        bus.hcount   = 10'(h0 + k % nh);
        bus.vcount   = 10'(v0 + k / nh);
        bus.video_on = vo;
      end else begin
        idle();
      end
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      if (k == 1) ra0 = bus.rom_addr;
      if (k >= 2) pix[k-2] = bus.pixel_on;
    end
  endtask

  logic [255:0] pix;
  logic [8:0]   ra;
  int           n;
  logic [7:0]   s_pen, s_hs, s_vs;
  logic [7:0]   g_h, g_v, g_o;
  int           ones, want;

  initial begin
    bus.pix_en    = 1'b1;
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_char   = '0;
    bus.clear_req = 1'b0;
    bus.cur_en    = 1'b0;
    bus.cur_col   = '0;
    bus.cur_row   = '0;
    idle();

    #12;
    chk("rst_pixel", 32'(bus.pixel_on), 0);
    chk("rst_vo", 32'(bus.video_on_o), 0);
    chk("rst_hs", 32'(bus.hsync_o), 0);
    chk("rst_vs", 32'(bus.vsync_o), 0);
    chk("rst_rom", 32'(bus.rom_addr), 0);
    chk("rst_busy", 32'(bus.busy), 1);

    @(negedge clk);
    reset_n     = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 11'd5;
    bus.wr_char = 6'd1;
    wait_busy(n);
    bus.wr_en = 1'b0;
    chk("busy_len_reset", n, 1200);
    scan(0, 1, 80, 16, 1'b1, pix, ra);
    chk("wr_during_busy", 32'(pix[15:0]), 0);

    wr(0, 1);
    wr(1, 6'h31);
    wr(1199, 1);
    wr(1200, 6'h31);

    scan(0, 1, 0, 16, 1'b1, pix, ra);
    chk("cell0_row0", 32'(pix[15:0]), 32'h03C0);
    chk("cell0_rom", 32'(ra), 32'h008);
    scan(2, 1, 16, 16, 1'b1, pix, ra);
    chk("cell1_row1", 32'(pix[15:0]), 32'h03C0);
    chk("cell1_rom", 32'(ra), 32'h189);
    scan(464, 1, 624, 16, 1'b1, pix, ra);
    chk("cell1199", 32'(pix[15:0]), 32'h03C0);
    scan(0, 1, 640, 16, 1'b1, pix, ra);
    chk("col40", 32'(pix[15:0]), 0);
    scan(0, 1, 0, 16, 1'b0, pix, ra);
    chk("blank_vo", 32'(pix[15:0]), 0);

    // write cell 0 in the same clk that first reads it
    bus.wr_en   = 1'b1;
    bus.wr_addr = 11'd0;
    bus.wr_char = 6'h31;
    scan(0, 1, 0, 16, 1'b1, pix, ra);
    chk("rbw_pix", 32'(pix[15:0]), 32'hFFFE);
    chk("rbw_rom", 32'(ra), 32'h008);

    s_pen = 8'hF7;
    s_hs  = 8'h65;
    s_vs  = 8'h4E;
    for (int k = 0; k < 8; k++) begin
      bus.pix_en   = s_pen[k];
      bus.hsync_in = s_hs[k];
      bus.vsync_in = s_vs[k];
      bus.video_on = s_hs[k];
      @(posedge clk); #1;
      g_h[k] = bus.hsync_o;
      g_v[k] = bus.vsync_o;
      g_o[k] = bus.video_on_o;
    end
    bus.pix_en   = 1'b1;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    idle();
    chk("hsync_dly", 32'(g_h), 32'hAC);
    chk("vsync_dly", 32'(g_v), 32'h30);
    chk("vo_dly", 32'(g_o), 32'hAC);
    repeat (3) @(posedge clk);
    #1;

    bus.clear_req = 1'b1;
    @(posedge clk); #1;
    bus.clear_req = 1'b0;
    wait_busy(n);
    chk("busy_len_clear", n, 1200);
    scan(0, 1, 0, 16, 1'b1, pix, ra);
    chk("clr_cell0", 32'(pix[15:0]), 0);
    scan(2, 1, 16, 16, 1'b1, pix, ra);
    chk("clr_cell1", 32'(pix[15:0]), 0);
    scan(464, 1, 624, 16, 1'b1, pix, ra);
    chk("clr_cell1199", 32'(pix[15:0]), 0);

    bus.clear_req = 1'b1;
    @(posedge clk); #1;
    bus.clear_req = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("busy_mid_clear", 32'(bus.busy), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("busy_in_reset", 32'(bus.busy), 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_busy(n);
    chk("busy_len_restart", n, 1200);

    // frame f is the one opened by the f-th frame tick since reset
    bus.cur_en  = 1'b1;
    bus.cur_col = 6'd0;
    bus.cur_row = 5'd0;
    for (int f = 1; f <= 62; f++) begin
      bus.cur_en = (f != 45);
      scan(0, 16, 0, 16, 1'b1, pix, ra);
      ones = $countones(pix);
      want = (f != 45 && ((f / 30) % 2) == 1) ? 256 : 0;
      chk($sformatf("blink_f%0d", f), ones, want);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
